// File: rtl/bin_dot_acc_pkg.sv
// -----------------------------------------------------------------------------
// bin_dot_acc_pkg
// Shared geometry and state encoding for the binary-neuron datapath. The
// fetch stage and the binary layers import this package so that they agree
// on lane width, lanes per beat, beats per frame and accumulator width.
// -----------------------------------------------------------------------------
package bin_dot_acc_pkg;

  localparam int DEF_DATA_W = 16;  // signed sample width
  localparam int DEF_LANES  = 5;   // samples per beat
  localparam int DEF_BEATS  = 4;   // beats per frame
  localparam int DEF_ACC_W  = 22;  // holds 20*32768 + 32768 without overflow

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : bin_dot_acc_pkg

// File: rtl/bin_lane_sum.sv
// -----------------------------------------------------------------------------
// bin_lane_sum
// Combinational binarized dot product of one beat: sum over lanes of
// (w ? +x : -x). Each lane is sign-extended to the sum width before it is
// negated, so -2^(DATA_W-1) negates cleanly to +2^(DATA_W-1).
//
// Ports:
//   lanes_i  LANES packed signed samples, lane j = [j*DATA_W +: DATA_W]
//   w_i      one weight bit per lane (1 = add, 0 = subtract)
//   sum_o    signed (DATA_W+4)-bit lane sum (headroom for up to 8 lanes)
// -----------------------------------------------------------------------------
module bin_lane_sum #(
  parameter int DATA_W = 16,
  parameter int LANES  = 5
) (
  input  logic [LANES*DATA_W-1:0]  lanes_i,
  input  logic [LANES-1:0]         w_i,
  output logic signed [DATA_W+3:0] sum_o
);

  localparam int SUM_W = DATA_W + 4;

  logic signed [SUM_W-1:0] x_ext;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves it holding its old value and no latch is inferred.
    sum_o = '0;
    x_ext = '0;
    for (int j = 0; j < LANES; j++) begin
      x_ext = SUM_W'($signed(lanes_i[j*DATA_W +: DATA_W]));
      sum_o = w_i[j] ? (sum_o + x_ext) : (sum_o - x_ext);
    end
  end

endmodule : bin_lane_sum

// File: rtl/bin_dot_acc.sv
// -----------------------------------------------------------------------------
// bin_dot_acc
// First binary-neuron layer of the VAD datapath. A start pulse latches the
// frame's binary weights and seeds the accumulator with the bias; each
// accepted beat then adds one binarized lane sum. The beat after the last
// one is a single DONE cycle that presents the pre-activation sum and its
// binarized sign. Results hold until the next accepted start.
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   start        begin a frame (accepted only in IDLE)
//   weight_bits  LANES*BEATS weights, bit k*LANES+j for lane j of beat k
//   bias         signed bias, sampled with start
//   in_valid     data_in holds a beat
//   data_in      LANES packed signed lanes
//   in_ready     beat accepted this cycle when in_valid is also high
//   busy         frame in progress
//   out_valid    one-cycle result strobe
//   acc_out      signed pre-activation sum
//   act_out      1 when acc_out >= 0
// -----------------------------------------------------------------------------
module bin_dot_acc
  import bin_dot_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int BEATS  = DEF_BEATS,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LANES*BEATS-1:0]    weight_bits,
  input  logic signed [DATA_W-1:0]  bias,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   data_in,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      out_valid,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic                      act_out
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W = DATA_W + 4;

  state_t                   state_q,   state_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic signed [ACC_W-1:0]  acc_q,     acc_d;
  logic [LANES*BEATS-1:0]   w_q,       w_d;
  logic signed [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic                     act_out_q, act_out_d;

  logic signed [SUM_W-1:0]  lane_sum;

  bin_lane_sum #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane_sum (
    .lanes_i (data_in),
    .w_i     (w_q[beat_cnt_q*LANES +: LANES]),
    .sum_o   (lane_sum)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    acc_d      = acc_q;
    w_d        = w_q;
    acc_out_d  = acc_out_q;
    act_out_d  = act_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d        = weight_bits;
          acc_d      = ACC_W'(bias);
          beat_cnt_d = '0;
          acc_out_d  = '0;
          act_out_d  = 1'b0;
          state_d    = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_d      = acc_q + ACC_W'(lane_sum);
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            // Result registers load on the last-beat edge so they are
            // already valid during the DONE cycle.
            acc_out_d  = acc_d;
            act_out_d  = ~acc_d[ACC_W-1];
            beat_cnt_d = '0;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      acc_q      <= '0;
      w_q        <= '0;
      acc_out_q  <= '0;
      act_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      acc_q      <= acc_d;
      w_q        <= w_d;
      acc_out_q  <= acc_out_d;
      act_out_q  <= act_out_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign acc_out   = acc_out_q;
  assign act_out   = act_out_q;

endmodule : bin_dot_acc

// File: tb/tb_bin_dot_acc.sv
// -----------------------------------------------------------------------------
// tb_bin_dot_acc
// Directed frames with hand-computed sums for bin_dot_acc: plain frames,
// all-negative-full-scale frames, stalled beats with stray start/in_valid
// pulses, and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_bin_dot_acc;

  localparam int DATA_W = 16;
  localparam int LANES  = 5;
  localparam int BEATS  = 4;
  localparam int ACC_W  = 22;
  localparam int NSAMP  = LANES * BEATS;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [NSAMP-1:0]         weight_bits;
  logic signed [DATA_W-1:0] bias;
  logic                     in_valid;
  logic [LANES*DATA_W-1:0]  data_in;
  logic                     in_ready;
  logic                     busy;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     act_out;

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;
  int samp [NSAMP];
  int gap  [BEATS];

  bin_dot_acc #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .BEATS  (BEATS),
    .ACC_W  (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .weight_bits (weight_bits),
    .bias        (bias),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .in_ready    (in_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .acc_out     (acc_out),
    .act_out     (act_out)
  );

  always #5 clk = ~clk;

  // out_valid pulses are counted mid-cycle, away from the active edge.
  always @(negedge clk) if (out_valid === 1'b1) ov_cnt++;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int k);
    for (int j = 0; j < LANES; j++) begin
      data_in[j*DATA_W +: DATA_W] = samp[k*LANES + j][DATA_W-1:0];
    end
  endtask

  task automatic drive_junk();
    for (int j = 0; j < LANES; j++) begin
      data_in[j*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  // Runs one frame; gap[k] idle cycles precede beat k. With inject set,
  // start pulses appear in the gaps and start+in_valid in the DONE cycle.
  task automatic run_frame(input string tag, input logic [NSAMP-1:0] w,
                           input int b, input bit inject,
                           input longint exp_acc, input bit exp_act);
    ov_cnt      = 0;
    start       = 1'b1;
    weight_bits = w;
    bias        = b[DATA_W-1:0];
    tick();
    start       = 1'b0;
    weight_bits = ~w;                 // weights and bias must be latched
    bias        = ~b[DATA_W-1:0];
    check({tag, " busy"}, busy, 1);
    check({tag, " clr_acc"}, acc_out, 0);
    check({tag, " clr_act"}, act_out, 0);
    for (int k = 0; k < BEATS; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        in_valid = 1'b0;
        start    = inject;
        drive_junk();
        tick();
        start    = 1'b0;
      end
      check({tag, " rdy"}, in_ready, 1);
      drive_beat(k);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    check({tag, " ov"}, out_valid, 1);
    check({tag, " acc"}, acc_out, exp_acc);
    check({tag, " act"}, act_out, exp_act);
    check({tag, " rdy_done"}, in_ready, 0);
    if (inject) begin
      start    = 1'b1;
      in_valid = 1'b1;
      drive_junk();
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, " ov_clr"}, out_valid, 0);
    check({tag, " idle"}, busy, 0);
    check({tag, " acc_hold"}, acc_out, exp_acc);
    check({tag, " act_hold"}, act_out, exp_act);
    tick();
    check({tag, " ov_cnt"}, ov_cnt, 1);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NSAMP; i++) samp[i] = i + 1;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NSAMP; i++) samp[i] = v;
  endtask

  task automatic no_gaps();
    for (int k = 0; k < BEATS; k++) gap[k] = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    weight_bits = '0;
    bias        = '0;
    in_valid    = 1'b0;
    data_in     = '0;
    tick();
    tick();
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    check("rst out_valid", out_valid, 0);
    check("rst acc_out", acc_out, 0);
    check("rst act_out", act_out, 0);
    rst_n = 1'b1;

    // in_valid while idle must not start anything.
    in_valid = 1'b1;
    drive_junk();
    tick();
    in_valid = 1'b0;
    check("idle ignores in_valid", busy, 0);

    // 1+2+...+20 = 210
    fill_ramp();
    no_gaps();
    run_frame("ramp_w1", 20'hFFFFF, 0, 1'b0, 210, 1'b1);
    // 5 - 210 = -205
    run_frame("ramp_w0", 20'h00000, 5, 1'b0, -205, 1'b0);
    // +1-2+3-...-20 = -10, then +10 bias gives exactly 0 (positive)
    run_frame("ramp_alt", 20'h55555, 0, 1'b0, -10, 1'b0);
    run_frame("ramp_alt_b10", 20'h55555, 10, 1'b0, 0, 1'b1);

    // 20 * 32768 + 32767 = 688127
    fill_const(-32768);
    run_frame("neg_w0", 20'h00000, 32767, 1'b0, 688127, 1'b1);
    // -20 * 32768 - 32768 = -688128
    run_frame("neg_w1", 20'hFFFFF, -32768, 1'b0, -688128, 1'b0);

    // Stalled beats with stray start / in_valid pulses.
    fill_ramp();
    gap[0] = 0; gap[1] = 3; gap[2] = 7; gap[3] = 0;
    run_frame("gaps", 20'hFFFFF, 0, 1'b1, 210, 1'b1);

    // Mid-frame reset after beat 2; acc_out currently holds 210.
    no_gaps();
    ov_cnt      = 0;
    start       = 1'b1;
    weight_bits = 20'hFFFFF;
    bias        = '0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_beat(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst in_ready", in_ready, 0);
    check("midrst busy", busy, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst acc_out", acc_out, 0);
    check("midrst act_out", act_out, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive_beat(c % BEATS);
      tick();
    end
    in_valid = 1'b0;
    check("midrst no out_valid", ov_cnt, 0);
    check("midrst stays idle", busy, 0);
    run_frame("after_rst", 20'hFFFFF, 0, 1'b0, 210, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bin_dot_acc

// File: doc/bin_dot_acc.md
Name: bin_dot_acc

Overview:
Downstream consumer of the frame-fetch stage. It accepts 5-lane groups of signed 16-bit samples, 4 beats per 20-sample frame, and applies one binarized weight per sample (+x or −x). It accumulates the 20 signed products plus a bias, then emits the pre-activation sum and the binarized activation (its sign bit). It forms the first binary-neuron layer of the VAD datapath.

Parameters:
DATA_W, 16, width of each signed input lane
LANES, 5, samples per input beat
BEATS, 4, beats per frame (LANES*BEATS = 20 weights)
ACC_W, 22, signed accumulator width; must be >= DATA_W+6

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a new frame accumulation
weight_bits  input  LANES*BEATS  binary weights (1 = +x, 0 = −x); sampled on accepted start
bias  input  DATA_W  signed bias; sampled on accepted start
in_valid  input  1  data_in carries a valid beat
data_in  input  LANES*DATA_W  packed lanes; lane j = bits [j*DATA_W +: DATA_W]
in_ready  output  1  block accepts a beat this cycle
busy  output  1  frame in progress (state != IDLE)
out_valid  output  1  one-cycle pulse; result valid
acc_out  output  ACC_W  signed pre-activation sum, held until next accepted start
act_out  output  1  binarized activation: 1 if acc_out >= 0, else 0; held with acc_out

Behaviour:
- Clock/reset: one clock clk; reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge): state=IDLE, beat_cnt=0, acc=0. Outputs in_ready=0, busy=0, out_valid=0, acc_out=0, act_out=0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 -> latch weight_bits and bias; acc <= sign_extend(bias); beat_cnt <= 0; go to ACC.
  - in_valid is ignored.
- ACC:
  - in_ready=1. A beat is accepted when in_valid=1.
  - On an accepted beat k = beat_cnt: acc <= acc + sum over j of (w[k*LANES+j] ? +x_j : −x_j), each x_j sign-extended to ACC_W before negation. −32768 therefore negates to +32768 with no overflow.
  - Lane sum and accumulate complete in one cycle; there is no pipeline inside a beat.
  - beat_cnt increments per accepted beat. The beat with beat_cnt = BEATS-1 moves the FSM to DONE.
  - in_valid=0 cycles stall accumulation with no loss; gaps of any length are allowed.
  - start while in ACC is ignored; the frame is not restarted.
- DONE (exactly one cycle):
  - out_valid=1; acc_out = final acc; act_out = ~acc[ACC_W-1].
  - in_ready=0. Next state is IDLE.
  - start in DONE is ignored.
- Latency: out_valid asserts 1 cycle after the clock edge accepting the last beat. Minimum frame time: start + 4 beats + 1 = 6 cycles; next start is accepted on the cycle after DONE.
- acc_out and act_out hold until the next accepted start, then clear to 0 and 0 on that edge.
- Reset mid-frame: abort immediately to the reset state. Partial accumulation is discarded and no out_valid is produced.
- Range: worst case |20*32768 + 32768| = 688128 < 2^21, so ACC_W=22 cannot overflow. No saturation logic.

Decomposition:
- Shared package: state encoding (IDLE/ACC/DONE), DATA_W, LANES, BEATS, ACC_W defaults. This lets fetch-stage and layer blocks share lane and frame geometry.
- One natural sub-module: bin_lane_sum. It is combinational; it takes LANES signed lanes plus LANES weight bits and returns a (DATA_W+4)-bit signed sum. It is reused by later binary layers.

Test Plan:
- Frame data 1..20 (lanes in order, 4 consecutive beats), all weights 1, bias 0 -> out_valid 1 cycle after beat 4, acc_out=210, act_out=1.
- Same data, all weights 0, bias 5 -> acc_out=−205, act_out=0.
- Same data, weights alternating 1,0 per sample (sample1 +), bias 0 -> acc_out=−10, act_out=0. With bias 10 -> acc_out=0, act_out=1 (zero counts as positive).
- All lanes −32768, weights 0, bias 32767 -> acc_out=688127, no overflow. Then all lanes −32768, weights 1, bias −32768 -> acc_out=−688128.
- Beats with in_valid gaps of 0, 3 and 7 cycles, plus start and in_valid pulses injected during ACC/DONE -> result identical to the first case; extra pulses ignored; exactly one out_valid.
- rst_n low for one cycle after beat 2 -> all outputs 0, no out_valid. A fresh start then runs the first case and yields 210.
